// File: rtl/red_seq.sv
// red_seq: multi-cycle lane reduction, one lane pair per clock.
// start/busy/done handshake, registered Sum with overflow flag.
module red_seq #(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             sgn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             ovf
);

  localparam int LANES = WIDTH / LANE_W;
  localparam int ACC_W = LANE_W + $clog2(2 * LANES) + 1;
  localparam int IW    = $clog2(LANES);
  localparam int BW    = ((ACC_W > WIDTH) ? ACC_W : WIDTH) + 2;

  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  localparam logic signed [BW-1:0] SMAX =
    (BW'(1) << (WIDTH - 1)) - BW'(1);
  localparam logic signed [BW-1:0] SMIN =
    -(BW'(1) << (WIDTH - 1));
  localparam logic [BW-1:0] UMAX =
    (BW'(1) << WIDTH) - BW'(1);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [ACC_W-1:0]  acc;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic              sg;

  logic [LANE_W-1:0] la;
  logic [LANE_W-1:0] lb;
  logic [ACC_W-1:0]  ea;
  logic [ACC_W-1:0]  eb;
  logic [ACC_W-1:0]  nxt;
  logic [BW-1:0]     wide;
  logic              ovf_n;
  logic              last;

  // Select current lanes, extend, accumulate, and check range.
  always_comb begin
    la    = opa[idx*LANE_W +: LANE_W];
    lb    = opb[idx*LANE_W +: LANE_W];
    ea    = {{(ACC_W-LANE_W){sg & la[LANE_W-1]}}, la};
    eb    = {{(ACC_W-LANE_W){sg & lb[LANE_W-1]}}, lb};
    nxt   = acc + ea + eb;
    wide  = {{(BW-ACC_W){sg & nxt[ACC_W-1]}}, nxt};
    last  = (idx == LAST);
    ovf_n = 1'b0;
    if (sg)
      ovf_n = ($signed(wide) > SMAX) ||
              ($signed(wide) < SMIN);
    else
      ovf_n = (wide > UMAX);
  end

  // Two-state controller with registered handshake and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
      opa   <= '0;
      opb   <= '0;
      sg    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Sum   <= '0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            opa   <= In1;
            opb   <= In2;
            sg    <= sgn;
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= nxt;
          idx <= idx + 1'b1;
          if (last) begin
            Sum   <= wide[WIDTH-1:0];
            ovf   <= ovf_n;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_red_seq.sv
// tb_red_seq: directed checks of red_seq in three configurations.
// Defaults (16/8), narrow overflow (3/1), four lanes (16/4).
module tb_red_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic        sta = 1'b0, sa = 1'b0;
  logic [15:0] in1a = '0, in2a = '0;
  logic        busya, donea, ovfa;
  logic [15:0] suma;

  logic        stb = 1'b0, sb = 1'b0;
  logic [2:0]  in1b = '0, in2b = '0;
  logic        busyb, doneb, ovfb;
  logic [2:0]  sumb;

  logic        stc = 1'b0, sc = 1'b0;
  logic [15:0] in1c = '0, in2c = '0;
  logic        busyc, donec, ovfc;
  logic [15:0] sumc;

  red_seq #(.WIDTH(16), .LANE_W(8)) ua (
    .clk(clk), .rst_n(rst_n), .start(sta),
    .In1(in1a), .In2(in2a), .sgn(sa),
    .busy(busya), .done(donea),
    .Sum(suma), .ovf(ovfa)
  );

  red_seq #(.WIDTH(3), .LANE_W(1)) ub (
    .clk(clk), .rst_n(rst_n), .start(stb),
    .In1(in1b), .In2(in2b), .sgn(sb),
    .busy(busyb), .done(doneb),
    .Sum(sumb), .ovf(ovfb)
  );

  red_seq #(.WIDTH(16), .LANE_W(4)) uc (
    .clk(clk), .rst_n(rst_n), .start(stc),
    .In1(in1c), .In2(in2c), .sgn(sc),
    .busy(busyc), .done(donec),
    .Sum(sumc), .ovf(ovfc)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic g_done(input int u);
    case (u)
      0: return donea;
      1: return doneb;
      default: return donec;
    endcase
  endfunction

  function automatic logic g_busy(input int u);
    case (u)
      0: return busya;
      1: return busyb;
      default: return busyc;
    endcase
  endfunction

  function automatic logic g_ovf(input int u);
    case (u)
      0: return ovfa;
      1: return ovfb;
      default: return ovfc;
    endcase
  endfunction

  function automatic logic [15:0] g_sum(input int u);
    case (u)
      0: return suma;
      1: return {13'd0, sumb};
      default: return sumc;
    endcase
  endfunction

  // One full operation on unit u, with latency and handshake checks.
  task automatic run(input int u, input string tag,
                     input logic [15:0] x,
                     input logic [15:0] y,
                     input logic s,
                     input logic [15:0] es,
                     input logic eo,
                     input int lat);
    int n;
    @(negedge clk);
    case (u)
      0: begin in1a = x; in2a = y; sa = s; sta = 1'b1; end
      1: begin
        in1b = x[2:0]; in2b = y[2:0]; sb = s; stb = 1'b1;
      end
      default: begin
        in1c = x; in2c = y; sc = s; stc = 1'b1;
      end
    endcase
    @(negedge clk);
    sta = 1'b0; stb = 1'b0; stc = 1'b0;
    check({tag, ".busy0"}, 32'(g_busy(u)), 32'd1);
    n = 0;
    while (!g_done(u) && n < 20) begin
      @(negedge clk);
      n++;
      if (!g_done(u))
        check({tag, ".busy"}, 32'(g_busy(u)), 32'd1);
    end
    check({tag, ".lat"}, 32'(n), 32'(lat));
    check({tag, ".done"}, 32'(g_done(u)), 32'd1);
    check({tag, ".busyd"}, 32'(g_busy(u)), 32'd0);
    check({tag, ".sum"}, 32'(g_sum(u)), 32'(es));
    check({tag, ".ovf"}, 32'(g_ovf(u)), 32'(eo));
    @(negedge clk);
    check({tag, ".pulse"}, 32'(g_done(u)), 32'd0);
    check({tag, ".hold"}, 32'(g_sum(u)), 32'(es));
  endtask

  initial begin
    // reset state
    @(negedge clk);
    check("rst.busy", 32'(busya), 32'd0);
    check("rst.done", 32'(donea), 32'd0);
    check("rst.sum",  32'(suma),  32'd0);
    check("rst.ovf",  32'(ovfa),  32'd0);
    rst_n = 1'b1;

    // basic unsigned and mode selection
    run(0, "basic", 16'h0102, 16'h0304, 1'b0, 16'h000A, 1'b0, 2);
    run(0, "uff",   16'hFFFF, 16'hFFFF, 1'b0, 16'h03FC, 1'b0, 2);
    run(0, "sff",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFC, 1'b0, 2);
    run(0, "s80",   16'h8080, 16'h8080, 1'b1, 16'hFE00, 1'b0, 2);

    // handshake: start while busy ignored, start in done cycle taken
    @(negedge clk);
    in1a = 16'h0101; in2a = 16'h0101; sa = 1'b0; sta = 1'b1;
    @(negedge clk);
    in1a = 16'h7F7F; in2a = 16'h7F7F;
    check("hs.busy", 32'(busya), 32'd1);
    @(negedge clk);
    check("hs.mid", 32'(donea), 32'd0);
    @(negedge clk);
    check("hs.done1", 32'(donea), 32'd1);
    check("hs.sum1", 32'(suma), 32'h0004);
    @(negedge clk);
    sta = 1'b0;
    check("hs.busy2", 32'(busya), 32'd1);
    check("hs.nodone", 32'(donea), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("hs.done2", 32'(donea), 32'd1);
    check("hs.sum2", 32'(suma), 32'h01FC);

    // reset mid-operation
    @(negedge clk);
    in1a = 16'h0102; in2a = 16'h0304; sta = 1'b1;
    @(negedge clk);
    sta = 1'b0;
    check("ab.busy0", 32'(busya), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ab.busy", 32'(busya), 32'd0);
    check("ab.done", 32'(donea), 32'd0);
    check("ab.sum",  32'(suma),  32'd0);
    @(negedge clk);
    @(negedge clk);
    check("ab.nodone", 32'(donea), 32'd0);
    rst_n = 1'b1;
    run(0, "post", 16'h0102, 16'h0304, 1'b0, 16'h000A, 1'b0, 2);

    // narrow overflow config
    run(1, "ovs", 16'h0007, 16'h0007, 1'b1, 16'h0002, 1'b1, 3);
    run(1, "ovu", 16'h0007, 16'h0007, 1'b0, 16'h0006, 1'b0, 3);

    // four-lane config
    run(2, "l4", 16'h1234, 16'h4321, 1'b0, 16'h0014, 1'b0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
